// File: rtl/ysyx_arbiter.sv
// ysyx_arbiter: IFU/LSU to single memory port arbiter.
// One outstanding transaction, IDLE -> REQ -> WAIT -> DONE.
//
// Parameters
//   WIDTH    address/data width; byte mask is WIDTH/8 bits
//   TIMEOUT  WAIT cycles before an error response (1..65535)
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ifu_req_*          IFU fetch request (valid/ready, addr)
//   ifu_resp_*         IFU one-cycle response (valid, rdata, err)
//   lsu_req_*          LSU request (valid/ready, addr, wen,
//                      wdata, wmask)
//   lsu_resp_*         LSU one-cycle response (valid, rdata, err)
//   mem_req_*          request to slave (valid/ready + fields)
//   mem_resp_*         slave response (valid, rdata, err)
//
// Build option
//   ARB_LSU_PRIORITY_EN  LSU wins every tie; otherwise
//                        round-robin between the masters.

module ysyx_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [WIDTH-1:0]   ifu_addr,
    output logic               ifu_resp_valid,
    output logic [WIDTH-1:0]   ifu_rdata,
    output logic               ifu_err,

    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [WIDTH-1:0]   lsu_addr,
    input  logic               lsu_wen,
    input  logic [WIDTH-1:0]   lsu_wdata,
    input  logic [WIDTH/8-1:0] lsu_wmask,
    output logic               lsu_resp_valid,
    output logic [WIDTH-1:0]   lsu_rdata,
    output logic               lsu_err,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [WIDTH-1:0]   mem_addr,
    output logic               mem_wen,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH/8-1:0] mem_wmask,
    input  logic               mem_resp_valid,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_err
);

    localparam int MW = WIDTH / 8;

    // Last WAIT cycle index before a forced error response.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] addr;
        logic             wen;
        logic [WIDTH-1:0] wdata;
        logic [MW-1:0]    wmask;
    } req_t;

    state_t           state_q, state_d;
    req_t             req_q, req_d;
    logic             owner_q, owner_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic gnt_ifu;
    logic gnt_lsu;
    logic tie_lsu;
    logic live;

    // owner_q: 1 = LSU owns the transaction, 0 = IFU.

`ifdef ARB_LSU_PRIORITY_EN
    assign tie_lsu = 1'b1;
`else
    logic last_lsu_q;

    // Updated as the transaction retires so the
    // other master wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_lsu_q <= 1'b1;
        end else if (state_q == S_DONE) begin
            last_lsu_q <= owner_q;
        end
    end

    assign tie_lsu = ~last_lsu_q;
`endif

    always_comb begin
        gnt_ifu = 1'b0;
        gnt_lsu = 1'b0;
        unique case (1'b1)
            (ifu_req_valid && lsu_req_valid): begin
                gnt_lsu = tie_lsu;
                gnt_ifu = ~tie_lsu;
            end
            (ifu_req_valid && !lsu_req_valid): begin
                gnt_ifu = 1'b1;
            end
            (!ifu_req_valid && lsu_req_valid): begin
                gnt_lsu = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (gnt_lsu) begin
                    req_d = '{
                        addr:  lsu_addr,
                        wen:   lsu_wen,
                        wdata: lsu_wdata,
                        wmask: lsu_wmask
                    };
                    owner_d = 1'b1;
                    state_d = S_REQ;
                end else if (gnt_ifu) begin
                    req_d = '{
                        addr:  ifu_addr,
                        wen:   1'b0,
                        wdata: '0,
                        wmask: '0
                    };
                    owner_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    // Stores never return read data.
                    if (owner_q && req_q.wen) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = mem_rdata;
                    end
                    err_d   = mem_err;
                    state_d = S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Handshake and pulse outputs are masked while reset is
    // held so an abandoned transaction never answers.
    assign live = ~rst;

    assign ifu_req_ready =
        live && (state_q == S_IDLE) && gnt_ifu;
    assign lsu_req_ready =
        live && (state_q == S_IDLE) && gnt_lsu;

    assign mem_req_valid = live && (state_q == S_REQ);
    assign mem_addr      = req_q.addr;
    assign mem_wen       = req_q.wen;
    assign mem_wdata     = req_q.wdata;
    assign mem_wmask     = req_q.wmask;

    assign ifu_resp_valid =
        live && (state_q == S_DONE) && !owner_q;
    assign lsu_resp_valid =
        live && (state_q == S_DONE) && owner_q;

    assign ifu_rdata = ifu_resp_valid ? rdata_q : '0;
    assign ifu_err   = ifu_resp_valid && err_q;
    assign lsu_rdata = lsu_resp_valid ? rdata_q : '0;
    assign lsu_err   = lsu_resp_valid && err_q;

endmodule

// File: tb/tb_ysyx_arbiter.sv
// tb_ysyx_arbiter: scoreboard bench for ysyx_arbiter.
// Transaction-level model predicts grants and responses.

module tb_ysyx_arbiter;

    localparam int W = 32;
    localparam int T = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_req_valid, ifu_req_ready;
    logic [W-1:0]  ifu_addr;
    logic          ifu_resp_valid;
    logic [W-1:0]  ifu_rdata;
    logic          ifu_err;
    logic          lsu_req_valid, lsu_req_ready;
    logic [W-1:0]  lsu_addr;
    logic          lsu_wen;
    logic [W-1:0]  lsu_wdata;
    logic [3:0]    lsu_wmask;
    logic          lsu_resp_valid;
    logic [W-1:0]  lsu_rdata;
    logic          lsu_err;
    logic          mem_req_valid, mem_req_ready;
    logic [W-1:0]  mem_addr;
    logic          mem_wen;
    logic [W-1:0]  mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_resp_valid;
    logic [W-1:0]  mem_rdata;
    logic          mem_err;

    ysyx_arbiter #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid),
        .ifu_req_ready(ifu_req_ready),
        .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid),
        .ifu_rdata(ifu_rdata),
        .ifu_err(ifu_err),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen),
        .lsu_wdata(lsu_wdata),
        .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid),
        .lsu_rdata(lsu_rdata),
        .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr),
        .mem_wen(mem_wen),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata(mem_rdata),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] addr;
        logic         wen;
        logic [W-1:0] wdata;
        logic [3:0]   wmask;
        bit           lsu;
    } mreq_t;

    typedef struct {
        int           cyc;
        logic [W-1:0] rdata;
        logic         err;
    } resp_t;

    typedef struct {
        int           stall;
        int           d;
        logic [W-1:0] data;
        logic         err;
    } dir_t;

    mreq_t exp_mem_q[$];
    resp_t ifu_q[$];
    resp_t lsu_q[$];
    dir_t  dir_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    bit busy     = 0;
    int pulse_at = -1;
    bit last_lsu = 1;

    int           sl_st = 0;
    int           stall_left, k, d;
    mreq_t        cur;
    logic [W-1:0] sdata;
    logic         serr;

    function automatic void check(string nm,
                                  logic [159:0] act,
                                  logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endfunction

    function automatic void fail_evt(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s at cycle %0d", nm, cyc);
    endfunction

    function automatic logic [159:0] all_outs();
        return {ifu_req_ready, ifu_resp_valid, ifu_rdata,
                ifu_err, lsu_req_ready, lsu_resp_valid,
                lsu_rdata, lsu_err, mem_req_valid, mem_addr,
                mem_wen, mem_wdata, mem_wmask};
    endfunction

    function automatic void pick_slave();
        int r;
        if (dir_q.size() > 0) begin
            dir_t e;
            e          = dir_q.pop_front();
            stall_left = e.stall;
            d          = e.d;
            sdata      = e.data;
            serr       = e.err;
        end else begin
            stall_left = ($urandom_range(0, 3) == 0)
                       ? $urandom_range(1, 5) : 0;
            r = $urandom_range(0, 9);
            if (r <= 5)      d = $urandom_range(0, 2);
            else if (r == 6) d = T - 1;
            else if (r == 7) d = T - 2;
            else if (r == 8) d = T;
            else             d = T + 1;
            sdata = $urandom;
            serr  = ($urandom_range(0, 7) == 0);
        end
    endfunction

    // Monitor, grant model and slave model, one step per
    // falling edge so their ordering is fixed.
    initial begin
        mem_req_ready  = 0;
        mem_resp_valid = 0;
        mem_rdata      = '0;
        mem_err        = 0;
        forever begin
            @(negedge clk);
            mem_req_ready  = 0;
            mem_resp_valid = 0;
            mem_rdata      = $urandom;
            mem_err        = 1'($urandom_range(0, 1));
            if (rst) begin
                exp_mem_q.delete();
                ifu_q.delete();
                lsu_q.delete();
                busy     = 0;
                pulse_at = -1;
                last_lsu = 1;
                sl_st    = 0;
            end else begin
                // IFU responses
                if (ifu_q.size() > 0 && ifu_q[0].cyc < cyc) begin
                    fail_evt("ifu_missed_resp");
                    void'(ifu_q.pop_front());
                end
                if (ifu_resp_valid) begin
                    if (ifu_q.size() == 0) begin
                        fail_evt("ifu_unexpected_resp");
                    end else begin
                        resp_t e;
                        e = ifu_q.pop_front();
                        check("ifu_resp_cycle", cyc, e.cyc);
                        check("ifu_rdata", ifu_rdata, e.rdata);
                        check("ifu_err", ifu_err, e.err);
                        check("lsu_quiet",
                              {lsu_resp_valid, lsu_rdata,
                               lsu_err}, 0);
                    end
                end
                // LSU responses
                if (lsu_q.size() > 0 && lsu_q[0].cyc < cyc) begin
                    fail_evt("lsu_missed_resp");
                    void'(lsu_q.pop_front());
                end
                if (lsu_resp_valid) begin
                    if (lsu_q.size() == 0) begin
                        fail_evt("lsu_unexpected_resp");
                    end else begin
                        resp_t e;
                        e = lsu_q.pop_front();
                        check("lsu_resp_cycle", cyc, e.cyc);
                        check("lsu_rdata", lsu_rdata, e.rdata);
                        check("lsu_err", lsu_err, e.err);
                        check("ifu_quiet",
                              {ifu_resp_valid, ifu_rdata,
                               ifu_err}, 0);
                    end
                end
                // Grant model
                begin
                    bit ei, el;
                    ei = 0;
                    el = 0;
                    if (!busy) begin
                        if (ifu_req_valid && lsu_req_valid) begin
`ifdef ARB_LSU_PRIORITY_EN
                            el = 1;
`else
                            el = !last_lsu;
`endif
                            ei = !el;
                        end else begin
                            ei = ifu_req_valid;
                            el = lsu_req_valid;
                        end
                    end
                    check("req_ready",
                          {ifu_req_ready, lsu_req_ready},
                          {ei, el});
                    if (ei || el) begin
                        mreq_t m;
                        busy     = 1;
                        pulse_at = -1;
                        last_lsu = el;
                        m.lsu    = el;
                        m.addr   = el ? lsu_addr : ifu_addr;
                        m.wen    = el ? lsu_wen : 1'b0;
                        m.wdata  = el ? lsu_wdata : '0;
                        m.wmask  = el ? lsu_wmask : 4'h0;
                        exp_mem_q.push_back(m);
                    end
                    if (busy && pulse_at == cyc) busy = 0;
                end
                // Slave
                if (sl_st == 0 && mem_req_valid) begin
                    if (exp_mem_q.size() == 0) begin
                        fail_evt("unexpected_mem_req");
                    end else begin
                        cur = exp_mem_q.pop_front();
                    end
                    pick_slave();
                    sl_st = 1;
                end
                if (sl_st == 1) begin
                    check("mem_req_valid", mem_req_valid, 1);
                    check("mem_fields",
                          {mem_addr, mem_wen, mem_wdata,
                           mem_wmask},
                          {cur.addr, cur.wen, cur.wdata,
                           cur.wmask});
                    if (stall_left == 0) begin
                        resp_t e;
                        mem_req_ready = 1;
                        sl_st = 2;
                        k = 0;
                        if (d <= T - 1) begin
                            e.cyc   = cyc + 2 + d;
                            e.rdata = cur.wen ? '0 : sdata;
                            e.err   = serr;
                        end else begin
                            e.cyc   = cyc + 1 + T;
                            e.rdata = '0;
                            e.err   = 1;
                        end
                        pulse_at = e.cyc;
                        if (cur.lsu) lsu_q.push_back(e);
                        else         ifu_q.push_back(e);
                    end else begin
                        stall_left--;
                        mem_resp_valid = 1'($urandom_range(0, 1));
                    end
                end else if (sl_st == 2) begin
                    if (k == d) begin
                        mem_resp_valid = 1;
                        mem_rdata      = sdata;
                        mem_err        = serr;
                        sl_st          = 0;
                    end else begin
                        k++;
                    end
                end
            end
        end
    end

    // Request tasks start and end just after a rising edge.
    task automatic req_ifu(input logic [W-1:0] a);
        bit ok;
        ok = 0;
        ifu_req_valid = 1;
        ifu_addr      = a;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ifu_req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_evt("ifu_req_timeout");
        @(posedge clk);
        #1;
        ifu_req_valid = 0;
        ifu_addr      = $urandom;
    endtask

    task automatic req_lsu(input logic         w,
                           input logic [W-1:0] a,
                           input logic [W-1:0] wd,
                           input logic [3:0]   m);
        bit ok;
        ok = 0;
        lsu_req_valid = 1;
        lsu_addr      = a;
        lsu_wen       = w;
        lsu_wdata     = wd;
        lsu_wmask     = m;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (lsu_req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_evt("lsu_req_timeout");
        @(posedge clk);
        #1;
        lsu_req_valid = 0;
        lsu_addr      = $urandom;
        lsu_wdata     = $urandom;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1;
        repeat (n) @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy && sl_st == 0 && ifu_q.size() == 0 &&
                lsu_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_evt("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ifu(input int n);
        logic [W-1:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            a = $urandom & 32'hFFFF_FFFC;
            req_ifu(a);
        end
    endtask

    task automatic rand_lsu(input int n);
        logic [W-1:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            a = $urandom & 32'hFFFF_FFFC;
            req_lsu(1'($urandom_range(0, 1)), a, $urandom,
                    4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        ifu_req_valid = 0;
        ifu_addr      = '0;
        lsu_req_valid = 0;
        lsu_addr      = '0;
        lsu_wen       = 0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        rst           = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        @(posedge clk);
        #1;
        rst = 0;

        // Single fetch, minimum latency
        dir_q.push_back('{0, 0, 32'hDEADBEEF, 1'b0});
        req_ifu(32'h8000_0000);
        wait_drain();

        // Tie straight after reset
        do_reset(2);
        dir_q.push_back('{0, 1, 32'hA5A5_0001, 1'b0});
        dir_q.push_back('{0, 1, 32'hA5A5_0002, 1'b0});
        fork
            req_ifu(32'h8000_0100);
            req_lsu(1'b0, 32'h8000_0200, 32'h0, 4'h0);
        join
        wait_drain();

        // Store with a 5-cycle request stall
        dir_q.push_back('{5, 1, 32'hCAFE_0000, 1'b0});
        req_lsu(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
        wait_drain();

        // Timeout, then a late slave response
        dir_q.push_back('{0, T + 1, 32'hBAD0_BAD0, 1'b0});
        req_lsu(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        wait_drain();

        // Slave error on a fetch
        dir_q.push_back('{0, 2, 32'h0000_1111, 1'b1});
        req_ifu(32'h8000_0004);
        wait_drain();

        // Reset in WAIT abandons the transaction
        dir_q.push_back('{0, T + 1, 32'h7777_7777, 1'b0});
        req_lsu(1'b0, 32'h8000_0030, 32'h0, 4'h0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sl_st == 2 && k >= 1) break;
        end
        do_reset(1);
        @(negedge clk);
        check("outputs_after_wait_reset", all_outs(), 0);
        repeat (T + 4) @(posedge clk);
        #1;

        // Random traffic
        fork
            rand_ifu(40);
            rand_lsu(40);
        join
        wait_drain();
        check("scoreboard_empty",
              {ifu_q.size() == 0, lsu_q.size() == 0,
               exp_mem_q.size() == 0},
              3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
